bky_shift_chain: RTL and testbench

- Datapath stage directly downstream of the Berkeley-register load controller.
- Consumes the controller's RDENA / SHFT_ENA / SET_DONE strobes and the 16-bit words from its first-word-fall-through FIFO.
- Serialises each word MSB-first into a WORDS*WIDTH-bit chain.
- On SET_DONE, checks that exactly WORDS*WIDTH bits were shifted, then publishes the chain as a parallel image with valid/error flags.

---
 rtl/bky_shift_chain.sv | 147 ++++++++++++++
 tb/tb_bky_shift_chain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bky_shift_chain.sv
// bky_shift_chain
// Serialising datapath stage that sits behind the Berkeley-register load
// controller. Each FIFO word is captured on RDENA, shifted out MSB-first on
// SHFT_ENA into a WORDS*WIDTH-bit chain, and the chain is published on the
// rising edge of SET_DONE if exactly WORDS*WIDTH bits were shifted and no
// RDENA/SHFT_ENA collision occurred during the load.
//
// Ports:
//   CLK        clock; all flops update on the falling edge
//   RST        asynchronous, active-high reset
//   START      load request level (rise restarts a load)
//   RDENA      FIFO pop / word-load strobe
//   SHFT_ENA   one-bit shift strobe
//   SET_DONE   load-complete level (rise triggers the count check)
//   DIN        FWFT FIFO head word
//   SDO        current serial bit (MSB of the word register)
//   DOUT       published parallel image
//   LOAD_VALID DOUT holds a complete, count-checked image
//   LOAD_ERR   last load ended with bad count or a strobe collision
//   BIT_CNT    bits shifted since the last START rise (saturating)
//
// All outputs come straight from flops; no input-to-output combinational path.

module bky_shift_chain #(
    parameter int WIDTH = 16,
    parameter int WORDS = 18,
    parameter int CNT_W = 9
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   RDENA,
    input  logic                   SHFT_ENA,
    input  logic                   SET_DONE,
    input  logic [WIDTH-1:0]       DIN,
    output logic                   SDO,
    output logic [WORDS*WIDTH-1:0] DOUT,
    output logic                   LOAD_VALID,
    output logic                   LOAD_ERR,
    output logic [CNT_W-1:0]       BIT_CNT
);

    localparam int N = WORDS * WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

    logic [WIDTH-1:0] word_q,    word_d;
    logic [N-1:0]     chain_q,   chain_d;
    logic [N-1:0]     dout_q,    dout_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic             coll_q,    coll_d;
    logic             start_d_q, start_d_d;
    logic             done_d_q,  done_d_d;

    logic start_rise;
    logic done_rise;
    logic do_shift;
    logic collide;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            word_q    <= '0;
            chain_q   <= '0;
            dout_q    <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            coll_q    <= 1'b0;
            start_d_q <= 1'b0;
            done_d_q  <= 1'b0;
        end else begin
            word_q    <= word_d;
            chain_q   <= chain_d;
            dout_q    <= dout_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            coll_q    <= coll_d;
            start_d_q <= start_d_d;
            done_d_q  <= done_d_d;
        end
    end

    always_comb begin
        start_rise = START & ~start_d_q;
        done_rise  = SET_DONE & ~done_d_q;
        // A load on the same edge as a shift wins; the shift is dropped.
        do_shift   = SHFT_ENA & ~RDENA;
        collide    = SHFT_ENA & RDENA;

        start_d_d  = START;
        done_d_d   = SET_DONE;
        word_d     = word_q;
        chain_d    = chain_q;
        dout_d     = dout_q;
        bit_cnt_d  = bit_cnt_q;
        valid_d    = valid_q;
        err_d      = err_q;
        coll_d     = coll_q;

        if (RDENA) begin
            word_d = DIN;
        end else if (do_shift) begin
            word_d = {word_q[WIDTH-2:0], 1'b0};
        end

        if (do_shift) begin
            chain_d = {chain_q[N-2:0], word_q[WIDTH-1]};
            if (bit_cnt_q != {CNT_W{1'b1}}) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (start_rise) begin
            // New load: restart the chain, keep the last published image.
            chain_d   = '0;
            bit_cnt_d = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            coll_d    = 1'b0;
        end else if (done_rise) begin
            // Check uses pre-edge count/chain; a shift on this edge is excluded.
            if (bit_cnt_q == FULL_CNT && !coll_q) begin
                dout_d  = chain_q;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end else begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
        end

        // A collision belongs to the load in progress, including one that
        // begins on this very edge.
        if (collide) begin
            coll_d = 1'b1;
        end
    end

    assign SDO        = word_q[WIDTH-1];
    assign DOUT       = dout_q;
    assign LOAD_VALID = valid_q;
    assign LOAD_ERR   = err_q;
    assign BIT_CNT    = bit_cnt_q;

endmodule

// File: tb/tb_bky_shift_chain.sv
module tb_bky_shift_chain;

  localparam int WIDTH = 16;
  localparam int WORDS = 18;
  localparam int CNT_W = 9;
  localparam int N     = WORDS * WIDTH;
  localparam int EXP_W = CNT_W + 2 + N;

  // ---------------- clock / reset ----------------
  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             START = 1'b0;
  logic             RDENA = 1'b0;
  logic             SHFT_ENA = 1'b0;
  logic             SET_DONE = 1'b0;
  logic [WIDTH-1:0] DIN = '0;
  logic             SDO;
  logic [N-1:0]     DOUT;
  logic             LOAD_VALID;
  logic             LOAD_ERR;
  logic [CNT_W-1:0] BIT_CNT;

  always #5 CLK = ~CLK;

  bky_shift_chain #(.WIDTH(WIDTH), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .RDENA(RDENA), .SHFT_ENA(SHFT_ENA),
    .SET_DONE(SET_DONE), .DIN(DIN), .SDO(SDO), .DOUT(DOUT),
    .LOAD_VALID(LOAD_VALID), .LOAD_ERR(LOAD_ERR), .BIT_CNT(BIT_CNT)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];   // {cnt, valid, err, dout}
  logic             sdo_q[$];
  logic [N-1:0]     m_img;      // image built from words as they are loaded
  logic [N-1:0]     m_dout;     // last published image
  int               m_cnt;
  bit               m_coll;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; DUT acts on the falling edge;
  // outputs are sampled on the next rising edge.
  task automatic tick();
    @(negedge CLK);
    @(posedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dout"},  DOUT, '0);
    check({tag, ".valid"}, LOAD_VALID, 0);
    check({tag, ".err"},   LOAD_ERR, 0);
    check({tag, ".cnt"},   BIT_CNT, 0);
    check({tag, ".sdo"},   SDO, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_load(input string tag);
    START = 1'b1;
    tick();
    check({tag, ".start_cnt"},   BIT_CNT, 0);
    check({tag, ".start_valid"}, LOAD_VALID, 0);
    m_img  = '0;
    m_cnt  = 0;
    m_coll = 0;
  endtask

  task automatic shift_word(input logic [WIDTH-1:0] w, input bit collide, input string tag);
    DIN = w;
    RDENA = 1'b1;
    SHFT_ENA = 1'b0;
    tick();
    if (collide) begin
      SHFT_ENA = 1'b1;
      tick();
      m_coll = 1;
      check({tag, ".coll_cnt"}, BIT_CNT, m_cnt);
      check({tag, ".coll_sdo"}, SDO, w[WIDTH-1]);
    end
    RDENA = 1'b0;
    SHFT_ENA = 1'b1;
    repeat (WIDTH) tick();
    SHFT_ENA = 1'b0;
    m_img = {m_img[N-WIDTH-1:0], w};
    m_cnt += WIDTH;
  endtask

  task automatic end_load(input string tag);
    logic             v, e;
    logic [EXP_W-1:0] x;
    if (m_cnt == N && !m_coll) begin
      m_dout = m_img;
      v = 1'b1;
      e = 1'b0;
    end else begin
      v = 1'b0;
      e = 1'b1;
    end
    exp_q.push_back({CNT_W'(m_cnt), v, e, m_dout});
    SET_DONE = 1'b1;
    tick();
    x = exp_q.pop_front();
    check({tag, ".cnt"},   BIT_CNT,    x[EXP_W-1 -: CNT_W]);
    check({tag, ".valid"}, LOAD_VALID, x[N+1]);
    check({tag, ".err"},   LOAD_ERR,   x[N]);
    check({tag, ".dout"},  DOUT,       x[N-1:0]);
    // SET_DONE held a second cycle must change nothing.
    tick();
    check({tag, ".hold_valid"}, LOAD_VALID, x[N+1]);
    check({tag, ".hold_dout"},  DOUT,       x[N-1:0]);
    SET_DONE = 1'b0;
    START = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] w;
    #2 RST = 1'b1;
    @(posedge CLK);
    check_zero("reset");
    m_dout = '0;
    RST = 1'b0;
    tick();

    // 1: nominal load
    start_load("nom");
    for (int i = 0; i < WORDS; i++) shift_word(16'hA5A0 + 16'(i), 0, "nom");
    end_load("nom");
    check("nom.top_word", DOUT[N-1 -: WIDTH], 16'hA5A0);
    check("nom.low_word", DOUT[WIDTH-1:0], 16'hA5B1);

    // 3: reload of all ones (LOAD_VALID was 1, start_rise must clear it)
    start_load("reload");
    for (int i = 0; i < WORDS; i++) shift_word(16'hFFFF, 0, "reload");
    end_load("reload");
    check("reload.ones", DOUT, {N{1'b1}});

    // 2: short load, previous image retained
    start_load("short");
    for (int i = 0; i < WORDS - 1; i++) shift_word(16'h0F00 + 16'(i), 0, "short");
    end_load("short");

    // 4: collision mid-load, otherwise full count
    start_load("coll");
    for (int i = 0; i < WORDS; i++) shift_word(16'h1234 + 16'(i * 7), i == 5, "coll");
    end_load("coll");

    // 5: serial bit order
    start_load("sdo");
    w = 16'h8001;
    for (int k = WIDTH - 1; k >= 0; k--) sdo_q.push_back(w[k]);
    sdo_q.push_back(1'b0);
    DIN = w;
    RDENA = 1'b1;
    tick();
    RDENA = 1'b0;
    check("sdo.bit", SDO, sdo_q.pop_front());
    SHFT_ENA = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      tick();
      check("sdo.bit", SDO, sdo_q.pop_front());
    end
    SHFT_ENA = 1'b0;
    START = 1'b0;
    tick();

    // 6: asynchronous reset mid-shift at word 9
    start_load("arst");
    for (int i = 0; i < 9; i++) shift_word(16'(i + 1), 0, "arst");
    DIN = 16'hFACE;
    RDENA = 1'b1;
    tick();
    RDENA = 1'b0;
    SHFT_ENA = 1'b1;
    repeat (5) tick();
    #2 RST = 1'b1;
    #1 check_zero("arst.now");
    SHFT_ENA = 1'b0;
    START = 1'b0;
    tick();
    RST = 1'b0;
    m_dout = '0;
    tick();
    start_load("post");
    for (int i = 0; i < WORDS; i++) shift_word(16'($urandom_range(0, 16'hFFFF)), 0, "post");
    end_load("post");

    check("sb.empty", exp_q.size() + sdo_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
